seg7_reader: RTL and testbench

Recovers hex digits from a multiplexed, active-low seven-segment bus and presents them as a packed binary value. It is the inverse of the team's hex-to-segment decoder. It sits on the display side of a design: in self-checking benches, and in on-board loopback where a display driver's outputs are routed back into the FPGA. Each digit pattern must be stable before it is decoded, and a frame is reported only once every digit position has been captured.

---
 rtl/seg7_reader.sv | 128 ++++++++++++
 tb/tb_seg7_reader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// seg7_reader: recovers hex digits from a multiplexed active-low 7-segment bus.
// Each digit must stay stable for STABLE cycles before it is accepted. A frame
// is published once every digit position has been captured with a legal pattern.
module seg7_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        seg_i,
  input  logic [NDIG-1:0]   dig_i,
  output logic [4*NDIG-1:0] value_o,
  output logic              frame_valid_o,
  output logic [NDIG-1:0]   digit_err_o,
  output logic              accept_o
);

  typedef enum logic {COLLECT, EMIT} state_t;

  localparam logic [3:0] STB = 4'(STABLE);

  // Returns {legal, nibble}; unknown patterns come back with legal = 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h10;  7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;  7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;  7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;  7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;  7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;  7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;  7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;  7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [6:0]             prev_seg_q;
  logic [NDIG-1:0]        prev_dig_q;
  logic [3:0]             cnt_q, cnt_d;
  logic                   hit_q, hit_d;
  logic [NDIG-1:0]        got_q, got_d;
  logic [NDIG-1:0][3:0]   stage_q, stage_d;
  logic [NDIG-1:0][3:0]   value_q, value_d;
  logic [NDIG-1:0]        err_q, err_d;
  logic                   fv_q, acc_q;
  logic                   onehot, same;
  logic [4:0]             dec;

  // Stability counter; hit fires once when the count first reaches STABLE.
  // The registered hit lines up with prev_seg/prev_dig holding the accepted pattern.
  always_comb begin
    onehot = (dig_i != '0) && ((dig_i & (dig_i - NDIG'(1))) == '0);
    same   = (seg_i == prev_seg_q) && (dig_i == prev_dig_q);
    cnt_d  = 4'd0;
    if (onehot) begin
      if (same) cnt_d = (cnt_q >= STB) ? STB : cnt_q + 4'd1;
      else      cnt_d = 4'd1;
    end
    hit_d = onehot && (cnt_d == STB) && !(same && (cnt_q == STB));
  end

  // Capture accepted digits into staging / error flags and run the frame FSM.
  // The got clear on EMIT happens before this cycle's acceptance is merged in.
  always_comb begin
    dec     = decode(prev_seg_q);
    stage_d = stage_q;
    err_d   = err_q;
    got_d   = (state_q == EMIT) ? '0 : got_q;
    value_d = value_q;
    state_d = state_q;
    if (hit_q) begin
      for (int i = 0; i < NDIG; i++) begin
        if (prev_dig_q[i]) begin
          if (dec[4]) begin
            stage_d[i] = dec[3:0];
            got_d[i]   = 1'b1;
          end else begin
            err_d[i] = 1'b1;
          end
        end
      end
    end
    case (state_q)
      COLLECT: if (&got_q) state_d = EMIT;
      EMIT: begin
        value_d = stage_q;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= COLLECT;
      prev_seg_q <= '0;
      prev_dig_q <= '0;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      got_q      <= '0;
      stage_q    <= '0;
      value_q    <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
      acc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_seg_q <= seg_i;
      prev_dig_q <= dig_i;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      got_q      <= got_d;
      stage_q    <= stage_d;
      value_q    <= value_d;
      err_q      <= err_d;
      fv_q       <= (state_q == EMIT);
      acc_q      <= hit_q;
    end
  end

  assign value_o       = value_q;
  assign frame_valid_o = fv_q;
  assign digit_err_o   = err_q;
  assign accept_o      = acc_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (NDIG=4, STABLE=3).
module tb_seg7_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic [15:0] value;
  logic        fv, acc;
  logic [3:0]  err;

  int n_chk = 0, n_fail = 0;
  int acc_cnt = 0, fv_cnt = 0;
  logic [15:0] last_val = '0;
  int a0, f0;

  seg7_reader #(.NDIG(4), .STABLE(3)) dut (
    .clk_i(clk), .rst_i(rst), .seg_i(seg), .dig_i(dig),
    .value_o(value), .frame_valid_o(fv), .digit_err_o(err), .accept_o(acc)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (acc) acc_cnt++;
    if (fv) begin
      fv_cnt++;
      last_val = value;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    seg = s;
    dig = d;
    repeat (n) tick();
  endtask

  task automatic mark();
    a0 = acc_cnt;
    f0 = fv_cnt;
  endtask

  initial begin
    // Reset with random inputs.
    rst = 1'b1;
    seg = 7'($urandom);
    dig = 4'($urandom);
    repeat (2) tick();
    chk("rst_value", value, 0);
    chk("rst_fv", fv, 0);
    chk("rst_err", err, 0);
    chk("rst_acc", acc, 0);
    rst = 1'b0;
    mark();
    hold(7'h7F, 4'b0000, 6);
    chk("rel_acc", acc_cnt - a0, 0);
    chk("rel_fv", fv_cnt - f0, 0);

    // Single frame with exact accept and frame latency checks.
    mark();
    seg = 7'h30; dig = 4'b0001;
    repeat (3) tick();
    chk("lat_acc_early", acc, 0);
    tick();
    chk("lat_acc", acc, 1);
    hold(7'h24, 4'b0010, 4);
    hold(7'h79, 4'b0100, 4);
    seg = 7'h40; dig = 4'b1000;
    repeat (4) tick();
    chk("lat_acc3", acc, 1);
    dig = 4'b0000;
    tick();
    chk("lat_fv_early", fv, 0);
    tick();
    chk("lat_fv", fv, 1);
    chk("lat_value", value, 16'h0123);
    hold(7'h7F, 4'b0000, 4);
    chk("f1_acc", acc_cnt - a0, 4);
    chk("f1_fv", fv_cnt - f0, 1);
    chk("f1_err", err, 0);

    // Glitch rejection on digit 1: toggling never accepts.
    mark();
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 7'h12 : 7'h02, 4'b0010, 1);
    chk("gl_toggle_acc", acc_cnt - a0, 0);
    hold(7'h12, 4'b0010, 2);
    chk("gl_short_acc", acc_cnt - a0, 0);
    hold(7'h12, 4'b0010, 6);
    chk("gl_hold_acc", acc_cnt - a0, 1);
    hold(7'h30, 4'b0001, 4);
    hold(7'h79, 4'b0100, 4);
    hold(7'h40, 4'b1000, 4);
    hold(7'h7F, 4'b0000, 4);
    chk("gl_fv", fv_cnt - f0, 1);
    chk("gl_value", last_val, 16'h0153);

    // Illegal pattern on digit 2 blocks the frame until a legal one arrives.
    mark();
    hold(7'h30, 4'b0001, 4);
    hold(7'h12, 4'b0010, 4);
    hold(7'h40, 4'b1000, 4);
    hold(7'h7F, 4'b0100, 5);
    hold(7'h7F, 4'b0000, 4);
    chk("il_err", err, 4'b0100);
    chk("il_acc", acc_cnt - a0, 4);
    chk("il_nofv", fv_cnt - f0, 0);
    hold(7'h79, 4'b0100, 4);
    hold(7'h7F, 4'b0000, 4);
    chk("il_fv", fv_cnt - f0, 1);
    chk("il_value", last_val, 16'h0153);
    chk("il_err_sticky", err, 4'b0100);

    // Overlap and blank are ignored.
    mark();
    hold(7'h0E, 4'b0011, 8);
    hold(7'h0E, 4'b0000, 8);
    chk("ov_acc", acc_cnt - a0, 0);
    hold(7'h0E, 4'b0001, 4);
    hold(7'h12, 4'b0010, 4);
    hold(7'h79, 4'b0100, 4);
    hold(7'h40, 4'b1000, 4);
    hold(7'h7F, 4'b0000, 4);
    chk("ov_fv", fv_cnt - f0, 1);
    chk("ov_value", last_val, 16'h015F);

    // Reset mid-frame discards partial progress.
    hold(7'h30, 4'b0001, 4);
    hold(7'h24, 4'b0010, 4);
    hold(7'h79, 4'b0100, 4);
    hold(7'h7F, 4'b0000, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_value", value, 0);
    chk("mr_err", err, 0);
    mark();
    hold(7'h40, 4'b1000, 4);
    hold(7'h7F, 4'b0000, 6);
    chk("mr_nofv", fv_cnt - f0, 0);
    hold(7'h30, 4'b0001, 4);
    hold(7'h24, 4'b0010, 4);
    hold(7'h79, 4'b0100, 4);
    hold(7'h7F, 4'b0000, 5);
    chk("mr_fv", fv_cnt - f0, 1);
    chk("mr_value2", last_val, 16'h0123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
